// File: rtl/mac_pre_sequencer.sv
// ----------------------------------------------------------------------------
// mac_pre_sequencer
//   Runs one MAC pre-processing instruction at a time. It accepts the
//   instruction, loads WFM beats into lanes one at a time, then streams IFM
//   beats to all lanes. Completion is reported over a done valid/ready
//   handshake.
//
//   The block owns the FIFO pop strobes, the one-hot per-lane WFM valid, the
//   lane IFM valid, and the latched datatype configuration that feeds the
//   decoders. All control outputs are combinational from state, counters and
//   inputs, so no handshake adds latency.
//
//   Optional feature macro: MAC_PRE_SEQ_BACK2BACK_EN
//     defined   : in DONE, instruction_ready follows done_ready. A new
//                 instruction can be accepted in the same cycle the done
//                 handshake completes, so there is no idle bubble.
//     undefined : instruction_ready is high only in IDLE. One idle cycle
//                 separates consecutive instructions.
// ----------------------------------------------------------------------------
module mac_pre_sequencer #(
    parameter int NUM_LANE = 64,
    parameter int W_LANE   = 7,
    parameter int W_CNT    = 16,
    parameter int W_DTYPE  = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,

    // instruction port
    output logic                seq_o_instruction_ready,
    input  logic                seq_i_instruction_valid,
    input  logic [W_DTYPE-1:0]  seq_i_ifm_datatype,
    input  logic [W_DTYPE-1:0]  seq_i_wfm_datatype,
    input  logic [W_LANE-1:0]   seq_i_wfm_lane_num,
    input  logic [W_CNT-1:0]    seq_i_ifm_beat_num,

    // latched decoder configuration
    output logic [W_DTYPE-1:0]  seq_o_ifm_datatype,
    output logic [W_DTYPE-1:0]  seq_o_wfm_datatype,

    // WFM path
    input  logic                seq_i_wfm_fifo_valid,
    output logic                seq_o_wfm_fifo_ready,
    output logic [NUM_LANE-1:0] seq_o_wfm_lane_valid,

    // IFM path
    input  logic                seq_i_ifm_fifo_valid,
    output logic                seq_o_ifm_fifo_ready,
    input  logic                seq_i_lane_ifm_ready,
    output logic                seq_o_lane_ifm_valid,

    // completion
    output logic                seq_o_done,
    input  logic                seq_i_done_ready,
    output logic                seq_o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WFM   = 2'd1,
        ST_STREAM_IFM = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    // Largest lane count a request is allowed to reload
    localparam logic [W_LANE-1:0]   LANE_MAX = W_LANE'(NUM_LANE);
    // Lane 0 write strobe; shifted by lane_cnt to address a lane
    localparam logic [NUM_LANE-1:0] LANE_ONE = NUM_LANE'(1);

    state_e               state_q,     state_d;
    logic [W_LANE-1:0]    lane_cnt_q,  lane_cnt_d;
    logic [W_LANE-1:0]    lane_num_q,  lane_num_d;
    logic [W_CNT-1:0]     beat_cnt_q,  beat_cnt_d;
    logic [W_CNT-1:0]     beat_num_q,  beat_num_d;
    logic [W_DTYPE-1:0]   ifm_dtype_q, ifm_dtype_d;
    logic [W_DTYPE-1:0]   wfm_dtype_q, wfm_dtype_d;

    logic [W_LANE-1:0]    lane_num_clamped;
    logic                 instr_accept;
    logic                 wfm_hs;
    logic                 ifm_hs;
    logic                 done_hs;
    logic                 lane_last;
    logic                 beat_last;

    // Clamp oversize lane requests to the physical lane count
    always_comb begin
        lane_num_clamped = (seq_i_wfm_lane_num > LANE_MAX) ? LANE_MAX : seq_i_wfm_lane_num;
    end

    // Handshake qualifiers and last-item detection for the two counters
    always_comb begin
        instr_accept = seq_o_instruction_ready & seq_i_instruction_valid;
        wfm_hs       = (state_q == ST_LOAD_WFM) & seq_i_wfm_fifo_valid;
        ifm_hs       = (state_q == ST_STREAM_IFM) & seq_i_ifm_fifo_valid & seq_i_lane_ifm_ready;
        done_hs      = (state_q == ST_DONE) & seq_i_done_ready;
        // lane_num_q / beat_num_q are non-zero whenever their state is active,
        // so the minus-one never underflows where it is used
        lane_last    = (lane_cnt_q == (lane_num_q - W_LANE'(1)));
        beat_last    = (beat_cnt_q == (beat_num_q - W_CNT'(1)));
    end

    // Combinational control outputs decoded from state, counters and inputs
    always_comb begin
        // NOTE: every output gets a default before the case; a path that
        // leaves one unassigned would infer a latch.
        seq_o_instruction_ready = 1'b0;
        seq_o_wfm_fifo_ready    = 1'b0;
        seq_o_wfm_lane_valid    = '0;
        seq_o_ifm_fifo_ready    = 1'b0;
        seq_o_lane_ifm_valid    = 1'b0;
        seq_o_done              = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                seq_o_instruction_ready = 1'b1;
            end
            ST_LOAD_WFM: begin
                seq_o_wfm_fifo_ready = 1'b1;
                if (seq_i_wfm_fifo_valid) begin
                    seq_o_wfm_lane_valid = LANE_ONE << lane_cnt_q;
                end
            end
            ST_STREAM_IFM: begin
                // Pop the IFM FIFO only when the lanes take the beat
                seq_o_lane_ifm_valid = seq_i_ifm_fifo_valid;
                seq_o_ifm_fifo_ready = seq_i_lane_ifm_ready;
            end
            ST_DONE: begin
                seq_o_done = 1'b1;
`ifdef MAC_PRE_SEQ_BACK2BACK_EN
                seq_o_instruction_ready = seq_i_done_ready;
`endif
            end
            default: begin
            end
        endcase
    end

    assign seq_o_busy         = (state_q != ST_IDLE);
    assign seq_o_ifm_datatype = ifm_dtype_q;
    assign seq_o_wfm_datatype = wfm_dtype_q;

    // Next-state, counter and instruction-latch logic
    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        lane_num_d  = lane_num_q;
        beat_cnt_d  = beat_cnt_q;
        beat_num_d  = beat_num_q;
        ifm_dtype_d = ifm_dtype_q;
        wfm_dtype_d = wfm_dtype_q;

        unique case (state_q)
            ST_IDLE: begin
                // Leaving IDLE happens only through the acceptance below
            end
            ST_LOAD_WFM: begin
                if (wfm_hs) begin
                    if (lane_last) begin
                        lane_cnt_d = '0;
                        state_d    = (beat_num_q != '0) ? ST_STREAM_IFM : ST_DONE;
                    end else begin
                        lane_cnt_d = lane_cnt_q + W_LANE'(1);
                    end
                end
            end
            ST_STREAM_IFM: begin
                if (ifm_hs) begin
                    if (beat_last) begin
                        beat_cnt_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + W_CNT'(1);
                    end
                end
            end
            ST_DONE: begin
                if (done_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance is possible in IDLE, or in DONE during the done
        // handshake when back-to-back issue is enabled. It overrides the
        // DONE->IDLE step so the new instruction starts immediately.
        if (instr_accept) begin
            ifm_dtype_d = seq_i_ifm_datatype;
            wfm_dtype_d = seq_i_wfm_datatype;
            lane_num_d  = lane_num_clamped;
            beat_num_d  = seq_i_ifm_beat_num;
            lane_cnt_d  = '0;
            beat_cnt_d  = '0;
            if (lane_num_clamped != '0) begin
                state_d = ST_LOAD_WFM;
            end else if (seq_i_ifm_beat_num != '0) begin
                state_d = ST_STREAM_IFM;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    // State register; reset aborts any instruction in flight and drops partial loads
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples its pre-edge value regardless of statement order.
        if (i_reset) begin
            state_q     <= ST_IDLE;
            lane_cnt_q  <= '0;
            lane_num_q  <= '0;
            beat_cnt_q  <= '0;
            beat_num_q  <= '0;
            ifm_dtype_q <= '0;
            wfm_dtype_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            lane_num_q  <= lane_num_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_num_q  <= beat_num_d;
            ifm_dtype_q <= ifm_dtype_d;
            wfm_dtype_q <= wfm_dtype_d;
        end
    end

    // Structural invariants of the control outputs
    a_lane_valid_onehot: assert property (
        @(posedge i_clk) disable iff (i_reset) $onehot0(seq_o_wfm_lane_valid));
    a_pops_exclusive: assert property (
        @(posedge i_clk) disable iff (i_reset) !(seq_o_wfm_fifo_ready && seq_o_ifm_fifo_ready));
    a_lane_cnt_in_range: assert property (
        @(posedge i_clk) disable iff (i_reset)
        (state_q == ST_LOAD_WFM) |-> (lane_cnt_q < lane_num_q));
    a_beat_cnt_in_range: assert property (
        @(posedge i_clk) disable iff (i_reset)
        (state_q == ST_STREAM_IFM) |-> (beat_cnt_q < beat_num_q));

endmodule
